mem_stage: RTL and testbench

//  MEM stage of the 5-stage forwarding pipeline. Sits between the EX/MEM register and WB.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/mem_stage_load_align.sv | 27 ++
 rtl/mem_stage.sv | 152 +++++++++++++++
 tb/tb_mem_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings and types for the MEM stage: access opcodes, FSM states,
// byte-enable patterns and the MEM/WB register layout.
package pipe_pkg;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SB   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SW   = 2'b11;

  localparam logic [2:0] MR_NONE = 3'b000;
  localparam logic [2:0] MR_LB   = 3'b001;
  localparam logic [2:0] MR_LBU  = 3'b010;
  localparam logic [2:0] MR_LH   = 3'b011;
  localparam logic [2:0] MR_LHU  = 3'b100;
  localparam logic [2:0] MR_LW   = 3'b101;

  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  typedef struct packed {
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] mem_data;
    logic [31:0] data_addr;
  } memwb_t;

  function automatic logic is_load(input logic [2:0] mr);
    return (mr >= MR_LB) && (mr <= MR_LW);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half/word out of the read word and extends it.
module load_align
  import pipe_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  mem_read,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (mem_read)
      MR_LB:   result = {{24{b[7]}}, b};
      MR_LBU:  result = {24'd0, b};
      MR_LH:   result = {{16{h[15]}}, h};
      MR_LHU:  result = {16'd0, h};
      MR_LW:   result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives the req/ack data port, stalls on wait states, aborts on
// timeout or misalignment, and holds the MEM/WB register.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemtoReg_inEXMEM,
  input  logic        RegWrite_inEXMEM,
  input  logic [1:0]  MemWrite_inEXMEM,
  input  logic [2:0]  MemRead_inEXMEM,
  input  logic [31:0] DataAddr_inEXMEM,
  input  logic [31:0] rfReadData2_inEXMEM,
  input  logic [4:0]  rd_Or_rt_inEXMEM,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        MemtoReg_inMEMWB,
  output logic        RegWrite_inMEMWB,
  output logic [4:0]  rd_Or_rt_inMEMWB,
  output logic [31:0] MemData_inMEMWB,
  output logic [31:0] DataAddr_inMEMWB
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e     state;
  logic [7:0] cnt;
  memwb_t     memwb, memwb_nxt;

  logic        is_st, is_ld, access, misalign, mis_err, abort;
  logic [1:0]  a;
  logic [31:0] d, ld_data;
  logic [NUM_LANES-1:0][VEC_W-1:0] wlane;

  assign a      = DataAddr_inEXMEM[1:0];
  assign d      = rfReadData2_inEXMEM;
  assign is_st  = MemWrite_inEXMEM != MW_NONE;
  assign is_ld  = !is_st && is_load(MemRead_inEXMEM);
  assign access = is_st || is_ld;

  always_comb begin
    misalign = 1'b0;
    if (is_st) begin
      case (MemWrite_inEXMEM)
        MW_SH:   misalign = a[0];
        MW_SW:   misalign = a != 2'b00;
        default: misalign = 1'b0;
      endcase
    end else if (is_ld) begin
      case (MemRead_inEXMEM)
        MR_LH, MR_LHU: misalign = a[0];
        MR_LW:         misalign = a != 2'b00;
        default:       misalign = 1'b0;
      endcase
    end
  end

  // Reset gates the request so an abandoned access drops off the bus at once.
  assign dm_req    = rst_n && ((state == S_IDLE && access && !misalign) || state == S_BUSY);
  assign mem_stall = dm_req && !dm_ack;
  assign mis_err   = state == S_IDLE && access && misalign;
  assign abort     = state == S_BUSY && !dm_ack && cnt == TMO;

  assign dm_we   = is_st;
  assign dm_addr = {DataAddr_inEXMEM[31:2], 2'b00};

  always_comb begin
    dm_be = BE_ALL;
    if (is_st) begin
      case (MemWrite_inEXMEM)
        MW_SB:   dm_be = BE_BYTE0 << a;
        MW_SH:   dm_be = a[1] ? BE_HALF_HI : BE_HALF_LO;
        default: dm_be = BE_ALL;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_comb begin
      case (MemWrite_inEXMEM)
        MW_SB:   wlane[i] = d[VEC_W-1:0];
        MW_SH:   wlane[i] = d[(i%2)*VEC_W +: VEC_W];
        default: wlane[i] = d[i*VEC_W +: VEC_W];
      endcase
    end
  end
  assign dm_wdata = wlane;

  load_align u_align (
    .rdata    (dm_rdata),
    .a        (a),
    .mem_read (MemRead_inEXMEM),
    .result   (ld_data)
  );

  // Stall cycles and error cycles load a bubble: fields pass, write-enable dropped.
  always_comb begin
    memwb_nxt.mem_to_reg = MemtoReg_inEXMEM;
    memwb_nxt.reg_write  = RegWrite_inEXMEM && !mem_stall && !mis_err;
    memwb_nxt.rd         = rd_Or_rt_inEXMEM;
    memwb_nxt.mem_data   = (is_ld && !mem_stall && !mis_err) ? ld_data : '0;
    memwb_nxt.data_addr  = DataAddr_inEXMEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      memwb   <= '0;
      mem_err <= 1'b0;
    end else begin
      memwb   <= memwb_nxt;
      mem_err <= abort || mis_err;
      case (state)
        S_IDLE: begin
          if (dm_req && !dm_ack) begin
            state <= S_BUSY;
            cnt   <= 8'd1;
          end
        end
        S_BUSY: begin
          if (dm_ack || cnt == TMO) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign MemtoReg_inMEMWB = memwb.mem_to_reg;
  assign RegWrite_inMEMWB = memwb.reg_write;
  assign rd_Or_rt_inMEMWB = memwb.rd;
  assign MemData_inMEMWB  = memwb.mem_data;
  assign DataAddr_inMEMWB = memwb.data_addr;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage with a behavioural memory-access model.
module tb_mem_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemtoReg_inEXMEM, RegWrite_inEXMEM;
  logic [1:0]  MemWrite_inEXMEM;
  logic [2:0]  MemRead_inEXMEM;
  logic [31:0] DataAddr_inEXMEM, rfReadData2_inEXMEM;
  logic [4:0]  rd_Or_rt_inEXMEM;
  logic        dm_req, dm_we, dm_ack, mem_stall, mem_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        MemtoReg_inMEMWB, RegWrite_inMEMWB;
  logic [4:0]  rd_Or_rt_inMEMWB;
  logic [31:0] MemData_inMEMWB, DataAddr_inMEMWB;

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemtoReg_inEXMEM(MemtoReg_inEXMEM), .RegWrite_inEXMEM(RegWrite_inEXMEM),
    .MemWrite_inEXMEM(MemWrite_inEXMEM), .MemRead_inEXMEM(MemRead_inEXMEM),
    .DataAddr_inEXMEM(DataAddr_inEXMEM), .rfReadData2_inEXMEM(rfReadData2_inEXMEM),
    .rd_Or_rt_inEXMEM(rd_Or_rt_inEXMEM),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_stall(mem_stall), .mem_err(mem_err),
    .MemtoReg_inMEMWB(MemtoReg_inMEMWB), .RegWrite_inMEMWB(RegWrite_inMEMWB),
    .rd_Or_rt_inMEMWB(rd_Or_rt_inMEMWB), .MemData_inMEMWB(MemData_inMEMWB),
    .DataAddr_inMEMWB(DataAddr_inMEMWB)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic        mtr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] mr, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] byt, half;
    byt  = (w >> (8 * a)) & 32'hFF;
    half = (w >> (16 * a[1])) & 32'hFFFF;
    case (mr)
      3'd1:    return (byt >= 32'd128) ? byt - 32'd256 : byt;
      3'd2:    return byt;
      3'd3:    return (half >= 32'd32768) ? half - 32'd65536 : half;
      3'd4:    return half;
      3'd5:    return w;
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: every write-back or error pulse consumes one expected entry.
  always @(negedge clk) begin
    if (rst_n && (RegWrite_inMEMWB || mem_err)) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_wb: got rw=%b err=%b required no output at %0t",
                 RegWrite_inMEMWB, mem_err, $time);
      end else begin
        me = q.pop_front();
        if (me.err) begin
          chk("err_pulse", 32'(mem_err), 32'd1);
          chk("err_bubble", 32'(RegWrite_inMEMWB), 32'd0);
        end else begin
          chk("wb_noerr", 32'(mem_err), 32'd0);
          chk("wb_mtr", 32'(MemtoReg_inMEMWB), 32'(me.mtr));
          chk("wb_rd", 32'(rd_Or_rt_inMEMWB), 32'(me.rd));
          chk("wb_data", MemData_inMEMWB, me.data);
          chk("wb_addr", DataAddr_inMEMWB, me.addr);
        end
      end
    end
  end

  // Called at a negedge; returns at the next negedge after the instruction leaves MEM.
  task automatic issue(input logic [1:0] mw, input logic [2:0] mr, input logic rw,
                       input logic mtr, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input int lat, input logic [31:0] rdata);
    bit st, ld, acc, mis;
    int n;
    logic [3:0] ebe;
    logic [31:0] ewd;
    exp_t e;
    MemWrite_inEXMEM = mw; MemRead_inEXMEM = mr; RegWrite_inEXMEM = rw;
    MemtoReg_inEXMEM = mtr; DataAddr_inEXMEM = a; rfReadData2_inEXMEM = d;
    rd_Or_rt_inEXMEM = rd; dm_rdata = rdata; dm_ack = 1'b0;
    st  = mw != 2'd0;
    ld  = !st && mr >= 3'd1 && mr <= 3'd5;
    acc = st || ld;
    mis = (st && mw == 2'd2 && a[0]) || (st && mw == 2'd3 && a[1:0] != 2'd0) ||
          (ld && (mr == 3'd3 || mr == 3'd4) && a[0]) || (ld && mr == 3'd5 && a[1:0] != 2'd0);
    ebe = !st ? 4'hF : (mw == 2'd1) ? 4'(1 << a[1:0]) : (mw == 2'd2) ? 4'(3 << (2 * a[1])) : 4'hF;
    ewd = (mw == 2'd1) ? (d & 32'hFF) * 32'h01010101 :
          (mw == 2'd2) ? (d & 32'hFFFF) * 32'h00010001 : d;
    e.err = 1'b0; e.mtr = mtr; e.rd = rd; e.addr = a;
    e.data = ld ? ld_model(mr, a[1:0], rdata) : 32'd0;
    if (acc && !mis) begin
      n = (lat > TMO) ? TMO : lat;
      for (int w = 0; w <= n; w++) begin
        dm_ack = (w == lat);
        #1;
        chk("dm_req", 32'(dm_req), 32'd1);
        chk("mem_stall", 32'(mem_stall), 32'(!dm_ack));
        if (w == 0) begin
          chk("dm_we", 32'(dm_we), 32'(st));
          chk("dm_addr", dm_addr, a & 32'hFFFF_FFFC);
          chk("dm_be", 32'(dm_be), 32'(ebe));
          if (st) chk("dm_wdata", dm_wdata, ewd);
        end
        if (w == n) begin
          if (lat > TMO) begin e.err = 1'b1; q.push_back(e); end
          else if (rw) q.push_back(e);
        end
        @(posedge clk); @(negedge clk);
      end
    end else begin
      #1;
      chk("no_req", 32'(dm_req), 32'd0);
      chk("no_stall", 32'(mem_stall), 32'd0);
      if (mis) begin e.err = 1'b1; q.push_back(e); end
      else if (rw) begin e.data = 32'd0; q.push_back(e); end
      @(posedge clk); @(negedge clk);
    end
    dm_ack = 1'b0;
  endtask

  task automatic nop();
    issue(2'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    MemtoReg_inEXMEM = 0; RegWrite_inEXMEM = 0; MemWrite_inEXMEM = 0; MemRead_inEXMEM = 0;
    DataAddr_inEXMEM = 0; rfReadData2_inEXMEM = 0; rd_Or_rt_inEXMEM = 0;
    #12;
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_rw", 32'(RegWrite_inMEMWB), 32'd0);
    chk("rst_data", MemData_inMEMWB, 32'd0);
    chk("rst_addr", DataAddr_inMEMWB, 32'd0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    issue(2'd0, 3'd5, 1, 1, 32'h10, 0, 5'd5, 0, 32'hDEADBEEF);
    issue(2'd0, 3'd1, 1, 1, 32'h13, 0, 5'd6, 0, 32'h80FF_FF7F);
    issue(2'd0, 3'd2, 1, 1, 32'h13, 0, 5'd7, 0, 32'h80FF_FF7F);
    issue(2'd0, 3'd3, 1, 1, 32'h12, 0, 5'd8, 0, 32'h80FF_FF7F);
    issue(2'd1, 3'd0, 0, 0, 32'h21, 32'h12345678, 5'd0, 0, 0);
    issue(2'd2, 3'd0, 0, 0, 32'h22, 32'h12345678, 5'd0, 0, 0);
    issue(2'd0, 3'd5, 1, 1, 32'h44, 0, 5'd9, 3, 32'hCAFEF00D);
    issue(2'd0, 3'd5, 1, 1, 32'h02, 0, 5'd10, 0, 32'h11111111);
    issue(2'd0, 3'd5, 1, 1, 32'h48, 0, 5'd11, 100, 32'h22222222);
    nop();

    // Reset in the middle of a waiting load.
    MemWrite_inEXMEM = 0; MemRead_inEXMEM = 3'd5; DataAddr_inEXMEM = 32'h40;
    RegWrite_inEXMEM = 1; MemtoReg_inEXMEM = 1; rd_Or_rt_inEXMEM = 5'd3; dm_ack = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mid_rst_req", 32'(dm_req), 32'd0);
    chk("mid_rst_stall", 32'(mem_stall), 32'd0);
    chk("mid_rst_addr", DataAddr_inMEMWB, 32'd0);
    chk("mid_rst_rd", 32'(rd_Or_rt_inMEMWB), 32'd0);
    chk("mid_rst_mtr", 32'(MemtoReg_inMEMWB), 32'd0);
    MemRead_inEXMEM = 0; RegWrite_inEXMEM = 0;
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    issue(2'd0, 3'd5, 1, 1, 32'h50, 0, 5'd12, 1, 32'h0BADC0DE);

    for (int i = 0; i < 400; i++) begin
      logic [1:0] mw;
      int r, lat;
      mw  = ($urandom % 3 == 0) ? 2'($urandom) : 2'd0;
      r   = $urandom % 10;
      lat = (r < 7) ? int'($urandom % 3) : int'($urandom_range(3, TMO + 2));
      issue(mw, 3'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
            5'($urandom), lat, $urandom);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
